// File: rtl/instruction_loader.sv
// Instruction-memory writer: takes a length-prefixed byte stream, packs big-endian
// 32-bit words and writes them from BASE_ADDR upward while holding the CPU stalled.
module instruction_loader #(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CW        = 7
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          mem_we,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          cpu_hold,
  output logic          done,
  output logic          error,
  output logic [CW-1:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [15:0] DEPTH_LEN = 16'(DEPTH);

  state_t          state_q;
  logic [7:0]      len_hi_q;
  logic [15:0]     remaining_q;
  logic [1:0]      byte_idx_q;
  logic [23:0]     word_q;
  logic            mem_we_q;
  logic [31:0]     mem_addr_q;
  logic [31:0]     mem_wdata_q;
  logic            cpu_hold_q;
  logic            done_q;
  logic            error_q;
  logic [CW-1:0]   words_loaded_q;

  logic            accept;
  logic [15:0]     length_d;
  logic [31:0]     word_d;

  // in_ready depends on state alone so the source never sees a combinational loop
  always_comb begin
    in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_DATA);
  end

  assign accept   = in_valid && in_ready;
  assign length_d = {len_hi_q, in_data};
  assign word_d   = {word_q, in_data};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      len_hi_q       <= '0;
      remaining_q    <= '0;
      byte_idx_q     <= '0;
      word_q         <= '0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= BASE_ADDR;
      mem_wdata_q    <= '0;
      cpu_hold_q     <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      words_loaded_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            words_loaded_q <= '0;
            mem_addr_q     <= BASE_ADDR;
            cpu_hold_q     <= 1'b1;
            byte_idx_q     <= '0;
            state_q        <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            len_hi_q <= in_data;
            state_q  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            if (length_d == 16'd0) begin
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
              state_q    <= S_DONE;
            end else if (length_d > DEPTH_LEN) begin
              error_q    <= 1'b1;
              cpu_hold_q <= 1'b0;
              state_q    <= S_ERROR;
            end else begin
              remaining_q <= length_d;
              byte_idx_q  <= '0;
              state_q     <= S_DATA;
            end
          end
        end
        S_DATA: begin
          // Shift left so the first byte of a word lands in bits [31:24]
          if (accept) begin
            word_q     <= word_d[23:0];
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              mem_we_q    <= 1'b1;
              mem_wdata_q <= word_d;
              state_q     <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          mem_we_q       <= 1'b0;
          mem_addr_q     <= mem_addr_q + 32'd4;
          words_loaded_q <= words_loaded_q + CW'(1);
          remaining_q    <= remaining_q - 16'd1;
          if (remaining_q == 16'd1) begin
            done_q     <= 1'b1;
            cpu_hold_q <= 1'b0;
            state_q    <= S_DONE;
          end else begin
            state_q <= S_DATA;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Writer side of the instruction memory. Receives a byte stream (length header followed by instruction bytes) over a valid/ready handshake.
- Assembles big-endian 32-bit words and drives the instruction memory write port at word-aligned byte addresses starting at BASE_ADDR.
- Holds the CPU stalled (cpu_hold) for the duration of a load so no fetch sees a partially written program.

Parameters:
- DEPTH, 64: instruction memory size in words; upper bound on accepted word count.
- BASE_ADDR, 32'h0000_0000: byte address of the first written word; must be a multiple of 4.
- CW, 7: width of words_loaded; must be at least clog2(DEPTH)+1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- in_valid  input  1  in_data holds a valid byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction memory write enable, one cycle per word.
- mem_addr  output  32  byte address of the write; always word-aligned.
- mem_wdata  output  32  assembled instruction word.
- cpu_hold  output  1  high from start until DONE or ERROR.
- done  output  1  load completed successfully; held until the next start.
- error  output  1  header length exceeded DEPTH; held until the next start.
- words_loaded  output  CW  number of words written in the current or last load.

Behaviour:
- Reset (asynchronous, reset_n low):
  - State goes to IDLE.
  - All outputs go to 0, except mem_addr, which goes to BASE_ADDR.
  - Any partial word and the length register are discarded.
  - Memory contents are not touched.
- Byte transfer: a byte is accepted in any cycle where in_valid && in_ready. in_ready is combinational from state only, never from in_valid.
- Outputs: all outputs except in_ready are registered.
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERROR.
- IDLE / DONE / ERROR:
  - in_ready = 0.
  - On start: clear done, error and words_loaded; set mem_addr = BASE_ADDR; set cpu_hold = 1; go to LEN_HI.
- LEN_HI: in_ready = 1. The accepted byte becomes length[15:8]; go to LEN_LO.
- LEN_LO: in_ready = 1. The accepted byte becomes length[7:0]. Then:
  - If the full 16-bit length is 0: go to DONE.
  - If length > DEPTH: go to ERROR.
  - Otherwise: set remaining = length and go to DATA.
- DATA:
  - in_ready = 1; a byte index counts 0..3.
  - The first byte accepted becomes word[31:24] and the fourth becomes word[7:0] (MIPS big-endian).
  - After the fourth byte is accepted, go to WRITE.
- WRITE:
  - in_ready = 0.
  - mem_we = 1 for exactly this cycle, with mem_wdata = assembled word and mem_addr = current address.
  - Latency: mem_we asserts in the cycle immediately after the fourth byte's handshake.
  - On leaving WRITE: mem_addr += 4, words_loaded += 1, remaining -= 1.
  - If remaining reaches 0, go to DONE; otherwise go to DATA.
- Entering DONE: cpu_hold = 0, done = 1. Entering ERROR: cpu_hold = 0, error = 1.
- Gaps and backpressure:
  - in_valid low holds state indefinitely; there is no timeout.
  - Bytes presented while in_ready = 0 are not consumed and must be held by the source.
- start while in LEN_HI, LEN_LO, DATA or WRITE is ignored.
- Address range: a full load of DEPTH words writes the last word at BASE_ADDR + 4*(DEPTH-1). mem_addr then reads BASE_ADDR + 4*DEPTH and is never used for a write.
- Reset mid-load: the in-flight word is not written. Words already written remain in memory. cpu_hold drops immediately with reset.

Test Plan:
- Basic load: start; stream 00 02 20 08 00 00 20 09 00 28. Required:
  - mem_we pulses twice: 0x20080000 at address 0x0, then 0x20090028 at address 0x4.
  - Each pulse occurs one cycle after the 4th byte of its word.
  - Then done = 1, cpu_hold = 0, words_loaded = 2.
- Zero length: start; stream 00 00 -> no mem_we; done = 1 in the cycle after the second byte; words_loaded = 0.
- Overflow: start; stream 00 41 (length 65, DEPTH 64) -> error = 1, done = 0, no mem_we, in_ready = 0 afterwards. A new start clears error.
- Backpressure and gaps:
  - Same stream as the basic load, with in_valid randomly deasserted and a byte presented during WRITE.
  - That byte is held, not consumed, until WRITE ends.
  - Written data matches the basic-load case exactly.
- Reset mid-word: after header 00 01 and bytes 8D 20, pulse reset_n low -> all outputs return to reset values and no mem_we occurs. A fresh load then writes correctly at address 0x0.
- Full depth and ignored start: load 64 words with a start pulse injected mid-stream.
  - The start has no effect.
  - The last write is at 0xFC; words_loaded = 64 and done = 1.
